// File: rtl/ddr2_v11_0_if_csr_m0_st_pkg.sv
// Shared types and helpers for the CSR-master Avalon-ST packet arbiter path.
package ddr2_v11_0_if_csr_m0_st_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  localparam int DEF_NUM_IN    = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CHANNEL_W = 8;

  // Width of a source index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr2_v11_0_if_csr_m0_rr_arbiter.sv
// Combinational rotating-priority pick: the first requester after 'last' wins.
module ddr2_v11_0_if_csr_m0_rr_arbiter
  import ddr2_v11_0_if_csr_m0_st_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int IDX_W  = idx_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [IDX_W-1:0]  grant,
  output logic              any
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_IN; i++) begin
      idx = IDX_W'((int'(last) + i) % NUM_IN);
      if (!any && req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr2_v11_0_if_csr_m0_st_packet_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_IN Avalon-ST sources into one
// registered stream tagged with the source index on out_channel.
module ddr2_v11_0_if_csr_m0_st_packet_arbiter
  import ddr2_v11_0_if_csr_m0_st_pkg::*;
#(
  parameter int NUM_IN    = DEF_NUM_IN,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CHANNEL_W = DEF_CHANNEL_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CHANNEL_W-1:0]     out_channel,
  output logic                     err_no_sop
);

  localparam int IDX_W = idx_w(NUM_IN);

  state_t           state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] pick;
  logic             pick_any;
  logic             first_beat;

  logic              sel_vld_p0;
  logic              sel_sop_p0;
  logic              sel_eop_p0;
  logic [DATA_W-1:0] sel_data_p0;
  logic              room_p0;
  logic              take_p0;

  ddr2_v11_0_if_csr_m0_rr_arbiter #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req   (in_valid),
    .last  (last_grant),
    .grant (pick),
    .any   (pick_any)
  );

  // Stage p0: select the granted source and decide whether its beat moves.
  always_comb begin
    sel_vld_p0  = 1'b0;
    sel_sop_p0  = 1'b0;
    sel_eop_p0  = 1'b0;
    sel_data_p0 = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == IDX_W'(i)) begin
        sel_vld_p0  = in_valid[i];
        sel_sop_p0  = in_startofpacket[i];
        sel_eop_p0  = in_endofpacket[i];
        sel_data_p0 = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign room_p0 = !out_valid || out_ready;
  assign take_p0 = (state == ST_BUSY) && sel_vld_p0 && room_p0;

  always_comb begin
    in_ready = '0;
    if (state == ST_BUSY && room_p0) in_ready[grant] = 1'b1;
  end

  // Stage p1: FSM plus the registered output beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      grant             <= '0;
      last_grant        <= IDX_W'(NUM_IN - 1);
      first_beat        <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_channel       <= '0;
      err_no_sop        <= 1'b0;
    end else begin
      err_no_sop <= 1'b0;
      if (take_p0) begin
        out_valid         <= 1'b1;
        out_data          <= sel_data_p0;
        out_startofpacket <= sel_sop_p0;
        out_endofpacket   <= sel_eop_p0;
        out_channel       <= CHANNEL_W'(grant);
        err_no_sop        <= first_beat && !sel_sop_p0;
        first_beat        <= 1'b0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: if (|in_valid) state <= ST_ARB;
        ST_ARB: begin
          if (pick_any) begin
            grant      <= pick;
            first_beat <= 1'b1;
            state      <= ST_BUSY;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // Grant stays locked until the granted source delivers its EOP.
          if (take_p0 && sel_eop_p0) begin
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_v11_0_if_csr_m0_st_packet_arbiter.sv
// Directed and randomized bench for the CSR packet arbiter with a
// packet-level round-robin reference model.
module tb_ddr2_v11_0_if_csr_m0_st_packet_arbiter;

  localparam int NUM_IN = 4;
  localparam int DATA_W = 8;
  localparam int CHANNEL_W = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [7:0] ch;
  } ob_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_startofpacket;
  logic [NUM_IN-1:0]        in_endofpacket;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic [CHANNEL_W-1:0]     out_channel;
  logic                     err_no_sop;

  ddr2_v11_0_if_csr_m0_st_packet_arbiter #(
    .NUM_IN    (NUM_IN),
    .DATA_W    (DATA_W),
    .CHANNEL_W (CHANNEL_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_ready          (in_ready),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_channel       (out_channel),
    .err_no_sop        (err_no_sop)
  );

  always #5 clk = ~clk;

  beat_t srcq [NUM_IN][$];
  beat_t refq [NUM_IN][$];
  ob_t   obs[$];
  int    obs_cyc[$];
  bit    rdy_pat[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mid_src = -1;
  int m_last = NUM_IN - 1;
  int exp_total = 0;
  int rdy_mode = 0;
  int held_cnt = 0;
  int err_cnt = 0;
  bit gap_en = 0;
  bit exp_err = 0;
  bit held = 0;
  logic [18:0] snap;

  task automatic check(input string tag, input logic [63:0] obsv, input logic [63:0] expv);
    checks++;
    assert (obsv === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obsv, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_IN; i++) begin
      if (srcq[i].size() > 0 && !(gap_en && mid_src == i && $urandom_range(0, 3) == 0)) begin
        in_valid[i]            = 1'b1;
        in_data[i*8 +: 8]      = srcq[i][0].data;
        in_startofpacket[i]    = srcq[i][0].sop;
        in_endofpacket[i]      = srcq[i][0].eop;
      end else begin
        in_valid[i]            = 1'b0;
        in_data[i*8 +: 8]      = 8'($urandom);
        in_startofpacket[i]    = 1'b0;
        in_endofpacket[i]      = 1'b0;
      end
    end
    case (rdy_mode)
      1:       out_ready = ($urandom_range(0, 99) < 70);
      2:       out_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
      default: out_ready = 1'b1;
    endcase
  endtask

  // One clock: sample and check at the falling edge, update stimulus after the rising edge.
  task automatic cycle();
    int    acc;
    beat_t b;
    ob_t   o;
    bit    nerr;
    bit    nheld;
    logic [18:0] nsnap;
    @(negedge clk);
    nerr  = 0;
    nheld = 0;
    acc   = -1;
    nsnap = {out_valid, out_data, out_startofpacket, out_endofpacket, out_channel};
    if (!reset) begin
      check("err_no_sop", err_no_sop, exp_err);
      check("in_ready_onehot", ($countones(in_ready) <= 1), 1'b1);
      if (mid_src >= 0) check("in_ready_track", in_ready[mid_src], (!out_valid || out_ready));
      if (held) check("hold_stable", nsnap, snap);
      if (err_no_sop) err_cnt++;
      if (out_valid && !out_ready) begin
        nheld = 1;
        held_cnt++;
      end
      if (out_valid && out_ready) begin
        o.data = out_data;
        o.sop  = out_startofpacket;
        o.eop  = out_endofpacket;
        o.ch   = out_channel;
        obs.push_back(o);
        obs_cyc.push_back(cyc);
      end
      for (int i = 0; i < NUM_IN; i++) if (in_valid[i] && in_ready[i]) acc = i;
      if (acc >= 0) begin
        b       = srcq[acc].pop_front();
        nerr    = (mid_src < 0) && !b.sop;
        mid_src = b.eop ? -1 : acc;
      end
    end else begin
      mid_src = -1;
    end
    snap = nsnap;
    held = nheld;
    @(posedge clk);
    #1;
    cyc++;
    exp_err = nerr;
    drive();
  endtask

  task automatic load_pkt(input int src, input int len, input logic [7:0] base, input bit nosop);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = base + 8'(k);
      b.sop  = (k == 0) && !nosop;
      b.eop  = (k == len - 1);
      srcq[src].push_back(b);
      refq[src].push_back(b);
    end
    exp_total += len;
  endtask

  task automatic run(input int budget);
    int n = 0;
    int left = 0;
    while (obs.size() < exp_total && n < budget) begin
      cycle();
      n++;
    end
    check("run_done", obs.size(), exp_total);
    for (int i = 0; i < NUM_IN; i++) left += srcq[i].size();
    check("src_drained", left, 0);
  endtask

  // Reference: whole packets granted in rotating order among sources with work left.
  task automatic compare_phase(input string tag);
    ob_t   e[$];
    ob_t   o;
    beat_t b;
    int    src;
    int    pending;
    forever begin
      src = -1;
      for (int k = 1; k <= NUM_IN; k++) begin
        if (src < 0 && refq[(m_last + k) % NUM_IN].size() > 0) src = (m_last + k) % NUM_IN;
      end
      if (src < 0) break;
      do begin
        b      = refq[src].pop_front();
        o.data = b.data;
        o.sop  = b.sop;
        o.eop  = b.eop;
        o.ch   = 8'(src);
        e.push_back(o);
      end while (!b.eop);
      m_last = src;
    end
    check($sformatf("%s_count", tag), obs.size(), e.size());
    pending = (obs.size() < e.size()) ? obs.size() : e.size();
    for (int k = 0; k < pending; k++) check($sformatf("%s_beat%0d", tag, k), obs[k], e[k]);
    obs.delete();
    obs_cyc.delete();
    exp_total = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      srcq[i].delete();
      refq[i].delete();
    end
    obs.delete();
    obs_cyc.delete();
    exp_total = 0;
    m_last = NUM_IN - 1;
    mid_src = -1;
    drive();
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, '0);
    check("rst_fields", {out_data, out_startofpacket, out_endofpacket, out_channel, err_no_sop}, '0);
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int e0;
    int h0;
    reset = 1'b1;
    drive();
    do_reset();

    // Single 3-beat packet from source 2: latency and channel tag.
    load_pkt(2, 3, 8'hA1, 0);
    drive();
    t0 = cyc;
    run(50);
    if (obs_cyc.size() == 3) begin
      check("t1_lat0", obs_cyc[0], t0 + 3);
      check("t1_lat1", obs_cyc[1], t0 + 4);
      check("t1_lat2", obs_cyc[2], t0 + 5);
      check("t1_chan", obs[0].ch, 8'd2);
    end
    compare_phase("t1");

    // Sources 0, 1, 3 each offering two 2-beat packets back to back.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      load_pkt(0, 2, 8'h10 + 8'(r * 2), 0);
      load_pkt(1, 2, 8'h20 + 8'(r * 2), 0);
      load_pkt(3, 2, 8'h30 + 8'(r * 2), 0);
    end
    drive();
    run(100);
    if (obs.size() == 12) begin
      check("t2_order0", obs[0].ch, 8'd0);
      check("t2_order2", obs[4].ch, 8'd3);
      check("t2_order3", obs[6].ch, 8'd0);
    end
    compare_phase("t2");

    // 4-beat packet with out_ready 1,0,0,1 once the first beat is out.
    rdy_mode = 2;
    rdy_pat = '{1, 1, 1, 1, 0, 0, 1};
    h0 = held_cnt;
    load_pkt(1, 4, 8'h40, 0);
    drive();
    run(60);
    check("t3_stalls", held_cnt - h0, 2);
    compare_phase("t3");
    rdy_mode = 0;

    // Reset while source 1 offers beat 2 of 4.
    load_pkt(1, 4, 8'h60, 0);
    drive();
    for (int n = 0; n < 20 && !(mid_src == 1 && srcq[1].size() == 3); n++) cycle();
    check("t4_mid_packet", srcq[1].size(), 3);
    do_reset();
    load_pkt(0, 2, 8'h70, 0);
    load_pkt(1, 2, 8'h78, 0);
    drive();
    run(60);
    if (obs.size() > 0) check("t4_first_src", obs[0].ch, 8'd0);
    compare_phase("t4");

    // Source 0 single beat without SOP.
    e0 = err_cnt;
    load_pkt(0, 1, 8'h55, 1);
    drive();
    run(30);
    cycle();
    check("t5_err_pulses", err_cnt - e0, 1);
    compare_phase("t5");

    // Back-to-back single-beat packets from source 3.
    load_pkt(3, 1, 8'h81, 0);
    load_pkt(3, 1, 8'h82, 0);
    load_pkt(3, 1, 8'h83, 0);
    drive();
    run(60);
    if (obs_cyc.size() == 3) begin
      check("t6_gap1", obs_cyc[1] - obs_cyc[0], 3);
      check("t6_gap2", obs_cyc[2] - obs_cyc[1], 3);
    end
    compare_phase("t6");

    // Randomized traffic with mid-packet valid gaps and random backpressure.
    rdy_mode = 1;
    gap_en = 1;
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < NUM_IN; s++) begin
        for (int p = $urandom_range(0, 3); p > 0; p--) begin
          load_pkt(s, $urandom_range(1, 4), 8'($urandom), ($urandom_range(0, 7) == 0));
        end
      end
      drive();
      run(3000);
      compare_phase($sformatf("rnd%0d", r));
    end
    rdy_mode = 0;
    gap_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
